clock_time_ctrl: RTL and testbench

- Time-keeping controller for the VGA clock. Holds BCD hours/minutes/seconds and advances them on a 1 Hz tick.
- Generates the shared clock-enable strobe that paces the three auto-repeat button pulse generators.
- Arbitrates their adjust pulses against the running tick, so that each cycle applies exactly one consistent update.
- Sits between the button pulse generators and the digit-rendering logic.

---
 rtl/clock_time_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl
// Time-keeping core for the VGA clock. Holds hours/minutes/seconds as BCD
// digits, advances them on a 1 Hz tick, applies the button adjust pulses,
// and produces the shared strobe that paces the auto-repeat pulse generators.
//
// Parameters:
//   BTN_DIV  clk cycles between btn_clk_en strobes (>= 2)
//   MODE_24  1 = hours 00..23, 0 = hours 01..12
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   tick_1hz    single-cycle 1 Hz enable
//   adj_hr      hour +1 pulse (no carry)
//   adj_min     minute +1 pulse (no carry into hours)
//   adj_sec     seconds-clear pulse
//   btn_clk_en  one-cycle strobe every BTN_DIV cycles
//   hr_t/hr_u, min_t/min_u, sec_t/sec_u  BCD time digits (registered)
//   updated     one-cycle pulse in the cycle a new time value appears
module clock_time_ctrl #(
  parameter int BTN_DIV = 3125000,
  parameter bit MODE_24 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       adj_hr,
  input  logic       adj_min,
  input  logic       adj_sec,
  output logic       btn_clk_en,
  output logic [1:0] hr_t,
  output logic [3:0] hr_u,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       updated
);

  localparam int DIV_W = (BTN_DIV > 2) ? $clog2(BTN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BTN_DIV - 1);

  // Reset time is midnight in 24 h mode and 12:00:00 in 12 h mode.
  localparam logic [1:0] RST_HR_T = MODE_24 ? 2'd0 : 2'd1;
  localparam logic [3:0] RST_HR_U = MODE_24 ? 4'd0 : 4'd2;

  // Which kind of update (if any) is applied this cycle.
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_ADJ,
    UPD_TICK
  } upd_class_e;

  logic [DIV_W-1:0] div_cnt;
  logic             tick_pending;

  upd_class_e upd_class;
  logic       adj_any;
  logic       pending_n;
  logic [5:0] hr_inc;
  logic [7:0] min_inc;
  logic [7:0] sec_inc;
  logic [1:0] hr_t_n;
  logic [3:0] hr_u_n;
  logic [2:0] min_t_n;
  logic [3:0] min_u_n;
  logic [2:0] sec_t_n;
  logic [3:0] sec_u_n;

  // Hour increment without carry out; the wrap point depends on the mode,
  // and 12 h mode skips from 12 straight to 01 so 00 never appears.
  function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] u);
    logic [5:0] r;
    if (MODE_24 && t == 2'd2 && u == 4'd3)
      r = {2'd0, 4'd0};
    else if (!MODE_24 && t == 2'd1 && u == 4'd2)
      r = {2'd0, 4'd1};
    else if (u == 4'd9)
      r = {t + 2'd1, 4'd0};
    else
      r = {t, u + 4'd1};
    return r;
  endfunction

  // Mod-60 BCD increment; bit 7 is the carry raised on the 59 -> 00 wrap.
  function automatic logic [7:0] sixty_inc(input logic [2:0] t, input logic [3:0] u);
    logic [7:0] r;
    if (u == 4'd9) begin
      if (t == 3'd5)
        r = {1'b1, 3'd0, 4'd0};
      else
        r = {1'b0, t + 3'd1, 4'd0};
    end else begin
      r = {1'b0, t, u + 4'd1};
    end
    return r;
  endfunction

  // Free-running divider for the button strobe; it ignores every input
  // except reset, so the pulse generators see a steady cadence.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      btn_clk_en <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      btn_clk_en <= 1'b1;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
      btn_clk_en <= 1'b0;
    end
  end

  // Arbitration and next-time computation. Adjust pulses win; a tick that
  // collides with them is parked in a one-deep pending flag and applied in
  // the first quiet cycle. A tick landing while one is already parked is
  // merged into it, so at most one advance ever comes out of the backlog.
  always_comb begin
    adj_any   = adj_hr | adj_min | adj_sec;
    hr_inc    = hour_inc(hr_t, hr_u);
    min_inc   = sixty_inc(min_t, min_u);
    sec_inc   = sixty_inc(sec_t, sec_u);
    hr_t_n    = hr_t;
    hr_u_n    = hr_u;
    min_t_n   = min_t;
    min_u_n   = min_u;
    sec_t_n   = sec_t;
    sec_u_n   = sec_u;
    pending_n = 1'b0;

    if (adj_any)
      upd_class = UPD_ADJ;
    else if (tick_1hz || tick_pending)
      upd_class = UPD_TICK;
    else
      upd_class = UPD_NONE;

    case (upd_class)
      UPD_ADJ: begin
        pending_n = tick_pending | tick_1hz;
        if (adj_hr)
          {hr_t_n, hr_u_n} = hr_inc;
        if (adj_min)
          {min_t_n, min_u_n} = min_inc[6:0];
        if (adj_sec) begin
          sec_t_n = 3'd0;
          sec_u_n = 4'd0;
        end
      end
      UPD_TICK: begin
        {sec_t_n, sec_u_n} = sec_inc[6:0];
        if (sec_inc[7]) begin
          {min_t_n, min_u_n} = min_inc[6:0];
          if (min_inc[7])
            {hr_t_n, hr_u_n} = hr_inc;
        end
      end
      default: ;
    endcase
  end

  // Time registers. Reset takes precedence over any pulse in the same
  // cycle and throws away a parked tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      hr_t         <= RST_HR_T;
      hr_u         <= RST_HR_U;
      min_t        <= 3'd0;
      min_u        <= 4'd0;
      sec_t        <= 3'd0;
      sec_u        <= 4'd0;
      tick_pending <= 1'b0;
      updated      <= 1'b0;
    end else begin
      hr_t         <= hr_t_n;
      hr_u         <= hr_u_n;
      min_t        <= min_t_n;
      min_u        <= min_u_n;
      sec_t        <= sec_t_n;
      sec_u        <= sec_u_n;
      tick_pending <= pending_n;
      updated      <= (upd_class != UPD_NONE);
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl
// Drives a 24 h and a 12 h instance of clock_time_ctrl from the same inputs.
// Expected values come from constant vector tables and an integer-arithmetic
// reference model; they are queued when stimulus is driven and popped when
// the outputs are sampled one cycle later.
module tb_clock_time_ctrl;

  localparam int BTN_DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset    = 1'b1;
  logic tick_1hz = 1'b0;
  logic adj_hr   = 1'b0;
  logic adj_min  = 1'b0;
  logic adj_sec  = 1'b0;

  logic       btn24, upd24, btn12, upd12;
  logic [1:0] hr_t24, hr_t12;
  logic [3:0] hr_u24, hr_u12, min_u24, min_u12, sec_u24, sec_u12;
  logic [2:0] min_t24, min_t12, sec_t24, sec_t12;

  clock_time_ctrl #(.BTN_DIV(BTN_DIV), .MODE_24(1'b1)) dut24 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .adj_hr(adj_hr), .adj_min(adj_min), .adj_sec(adj_sec),
    .btn_clk_en(btn24), .hr_t(hr_t24), .hr_u(hr_u24),
    .min_t(min_t24), .min_u(min_u24), .sec_t(sec_t24), .sec_u(sec_u24),
    .updated(upd24)
  );

  clock_time_ctrl #(.BTN_DIV(BTN_DIV), .MODE_24(1'b0)) dut12 (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .adj_hr(adj_hr), .adj_min(adj_min), .adj_sec(adj_sec),
    .btn_clk_en(btn12), .hr_t(hr_t12), .hr_u(hr_u12),
    .min_t(min_t12), .min_u(min_u12), .sec_t(sec_t12), .sec_u(sec_u12),
    .updated(upd12)
  );

  // Vector record: inputs plus the expected 24 h time as decimal hhmmss.
  typedef struct {
    string name;
    logic  rst, tick, ah, am, as;
    int    exp24;
  } vec_t;

  // Scoreboard entry for one cycle.
  typedef struct {
    string name;
    int    t24;
    int    t12;
    logic  upd;
    logic  btn;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[26];
  int   tests_run    = 0;
  int   tests_failed = 0;

  int   mh[2], mm[2], ms[2];
  logic m_pend = 1'b0;
  int   m_cyc  = 0;

  function automatic int hinc(input int h, input int k);
    if (k == 0) return (h + 1) % 24;
    return (h == 12) ? 1 : h + 1;
  endfunction

  // Reference model: plain integers, index 0 = 24 h unit, 1 = 12 h unit.
  task automatic model_step(input logic r, t, ah, am, as, output exp_t e);
    logic adj, do_tick;
    if (r) begin
      mh[0] = 0; mh[1] = 12;
      for (int k = 0; k < 2; k++) begin mm[k] = 0; ms[k] = 0; end
      m_pend = 1'b0; m_cyc = 0;
      e.upd = 1'b0; e.btn = 1'b0;
    end else begin
      m_cyc++;
      e.btn   = ((m_cyc % BTN_DIV) == 0);
      adj     = ah | am | as;
      do_tick = !adj && (t || m_pend);
      m_pend  = adj ? (m_pend | t) : 1'b0;
      e.upd   = adj | do_tick;
      for (int k = 0; k < 2; k++) begin
        if (adj) begin
          if (ah) mh[k] = hinc(mh[k], k);
          if (am) mm[k] = (mm[k] + 1) % 60;
          if (as) ms[k] = 0;
        end else if (do_tick) begin
          ms[k]++;
          if (ms[k] == 60) begin
            ms[k] = 0; mm[k]++;
            if (mm[k] == 60) begin mm[k] = 0; mh[k] = hinc(mh[k], k); end
          end
        end
      end
    end
    e.t24 = mh[0] * 10000 + mm[0] * 100 + ms[0];
    e.t12 = mh[1] * 10000 + mm[1] * 100 + ms[1];
  endtask

  function automatic int bcd_time(input logic [1:0] ht, input logic [3:0] hu,
                                  input logic [2:0] mt, input logic [3:0] mu,
                                  input logic [2:0] st, input logic [3:0] su);
    return int'(ht) * 100000 + int'(hu) * 10000 + int'(mt) * 1000 +
           int'(mu) * 100 + int'(st) * 10 + int'(su);
  endfunction

  task automatic check1(input string name, input string what, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d", name, what, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb_q.pop_front();
    check1(e.name, "time24", bcd_time(hr_t24, hr_u24, min_t24, min_u24, sec_t24, sec_u24), e.t24);
    check1(e.name, "time12", bcd_time(hr_t12, hr_u12, min_t12, min_u12, sec_t12, sec_u12), e.t12);
    check1(e.name, "updated24", int'(upd24), int'(e.upd));
    check1(e.name, "updated12", int'(upd12), int'(e.upd));
    check1(e.name, "btn24", int'(btn24), int'(e.btn));
    check1(e.name, "btn12", int'(btn12), int'(e.btn));
  endtask

  // exp24 < 0 means the 24 h expectation comes from the model.
  task automatic applyStimulus(input string name, input logic r, t, ah, am, as, input int exp24);
    exp_t e;
    @(negedge clk);
    reset = r; tick_1hz = t; adj_hr = ah; adj_min = am; adj_sec = as;
    model_step(r, t, ah, am, as, e);
    e.name = name;
    if (exp24 >= 0) e.t24 = exp24;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      applyStimulus(tbl[i].name, tbl[i].rst, tbl[i].tick, tbl[i].ah, tbl[i].am, tbl[i].as, tbl[i].exp24);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = '{"tick_2359", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 235959};
    tbl[1]  = '{"tick_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{"idle_wrap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    for (int i = 0; i < 10; i++)
      tbl[3 + i] = '{"adj_hr_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (i + 1) * 10000};
    tbl[13] = '{"tick_adjmin", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 100030};
    tbl[14] = '{"deferred_1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100031};
    tbl[15] = '{"quiet_1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100031};
    tbl[16] = '{"tick_adjsec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 50700};
    tbl[17] = '{"tick_adjhr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 60700};
    tbl[18] = '{"deferred_2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 60701};
    tbl[19] = '{"dropped", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 60701};
    tbl[20] = '{"sec_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 60700};
    tbl[21] = '{"sec_clear_00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 60700};
    tbl[22] = '{"pend_set", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 71620};
    tbl[23] = '{"reset_mid", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[24] = '{"post_reset1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[25] = '{"post_reset2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    repeat (2) applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int c = 1; c <= 2 * BTN_DIV; c++)
      applyStimulus("divider", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Preload 23:59:58 (the 12 h unit lands on 11:59:58).
    repeat (23) applyStimulus("pre_hr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    repeat (59) applyStimulus("pre_min", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (58) applyStimulus("pre_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_table(0, 12);

    // Move to 10:59:30.
    repeat (59) applyStimulus("pre_min", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (30) applyStimulus("pre_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_table(13, 15);

    // Move to 05:07:45.
    repeat (19) applyStimulus("pre_hr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    repeat (7)  applyStimulus("pre_min", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (14) applyStimulus("pre_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_table(16, 21);

    // Move to 07:15:20.
    applyStimulus("pre_hr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    repeat (8)  applyStimulus("pre_min", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (20) applyStimulus("pre_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_table(22, 25);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
